// File: rtl/muntjac_irq_ctrl_if.sv
// CSR access port and trap request handshake between the CSR/pipeline side
// (master) and the interrupt controller (slave).
interface muntjac_irq_ctrl_if;
   logic        csr_we_i;
   logic [1:0]  csr_op_i;
   logic [11:0] csr_addr_i;
   logic [63:0] csr_wdata_i;
   logic [63:0] csr_rdata_o;
   logic        csr_hit_o;
   logic        irq_valid_o;
   logic [4:0]  irq_cause_o;
   logic        irq_ack_i;

   modport master (
      output csr_we_i, csr_op_i, csr_addr_i, csr_wdata_i, irq_ack_i,
      input  csr_rdata_o, csr_hit_o, irq_valid_o, irq_cause_o
   );

   modport slave (
      input  csr_we_i, csr_op_i, csr_addr_i, csr_wdata_i, irq_ack_i,
      output csr_rdata_o, csr_hit_o, irq_valid_o, irq_cause_o
   );
endinterface

// File: rtl/muntjac_irq_ctrl.sv
// Machine/supervisor interrupt controller: input synchronizers, mip/mie/sip/sie
// CSRs, privilege-aware priority selection and a trap request handshake FSM.
module muntjac_irq_ctrl #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        irq_software_m_i,
   input  logic        irq_timer_m_i,
   input  logic        irq_external_m_i,
   input  logic        irq_external_s_i,
   input  logic [1:0]  prv_i,
   input  logic        status_mie_i,
   input  logic        status_sie_i,
   input  logic [63:0] mideleg_i,
   output logic [63:0] mip_o,
   output logic [63:0] mie_o,
   output logic        wfi_wakeup_o,
   muntjac_irq_ctrl_if.slave bus
);

   localparam logic [11:0] CSR_SIE = 12'h104;
   localparam logic [11:0] CSR_SIP = 12'h144;
   localparam logic [11:0] CSR_MIE = 12'h304;
   localparam logic [11:0] CSR_MIP = 12'h344;

   localparam logic [1:0] CSR_OP_READ  = 2'd0;
   localparam logic [1:0] CSR_OP_WRITE = 2'd1;
   localparam logic [1:0] CSR_OP_SET   = 2'd2;
   localparam logic [1:0] CSR_OP_CLEAR = 2'd3;

   localparam logic [1:0] PRV_U = 2'd0;
   localparam logic [1:0] PRV_S = 2'd1;
   localparam logic [1:0] PRV_M = 2'd3;

   localparam logic [63:0] MIE_MASK = 64'h0000_0000_0000_0AAA;
   localparam logic [63:0] S_MASK   = 64'h0000_0000_0000_0222;

   typedef enum logic [1:0] {IDLE, PEND, HOLDOFF} state_e;

   function automatic logic [63:0] apply_op(input logic [1:0] op, input logic [63:0] old_val,
                                            input logic [63:0] wdata);
      case (op)
         CSR_OP_WRITE: return wdata;
         CSR_OP_SET:   return old_val | wdata;
         CSR_OP_CLEAR: return old_val & ~wdata;
         default:      return old_val;
      endcase
   endfunction

   // Returns {found, code}; walks lowest priority first so the highest one wins.
   function automatic logic [4:0] pick(input logic [11:0] set);
      logic [3:0] prio [6];
      logic [4:0] result;
      prio   = '{4'd11, 4'd3, 4'd7, 4'd9, 4'd1, 4'd5};
      result = '0;
      for (int i = 5; i >= 0; i--) begin
         if (set[prio[i]]) result = {1'b1, prio[i]};
      end
      return result;
   endfunction

   // ---------------------------------------------------------------- synchronizers
   logic [3:0] irq_raw;
   logic [3:0] irq_sync;

   assign irq_raw = {irq_external_s_i, irq_external_m_i, irq_timer_m_i, irq_software_m_i};

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_sync
         logic [SYNC_STAGES-1:0] chain_reg;
         logic [SYNC_STAGES:0]   chain_next;

         assign chain_next = {chain_reg, irq_raw[gi]};

         always_ff @(posedge clk_i) begin
            if (!rst_ni) chain_reg <= '0;
            else         chain_reg <= chain_next[SYNC_STAGES-1:0];
         end

         assign irq_sync[gi] = chain_reg[SYNC_STAGES-1];
      end
   endgenerate

   // ---------------------------------------------------------------- CSR state
   logic [63:0] mie_reg, mie_next;
   logic        ssip_reg, ssip_next;
   logic        stip_reg, stip_next;
   logic        seip_reg, seip_next;
   logic [63:0] mip;
   logic [63:0] sflop_vec;
   logic [63:0] sip_val;
   logic [63:0] sie_val;
   logic [63:0] deleg_s;
   logic        wr_en;
   logic [63:0] wr_new;

   always_comb begin
      mip       = '0;
      mip[1]    = ssip_reg;
      mip[3]    = irq_sync[0];
      mip[5]    = stip_reg;
      mip[7]    = irq_sync[1];
      mip[9]    = seip_reg | irq_sync[3];
      mip[11]   = irq_sync[2];
      // Read-modify-write of mip operates on the flops only, so a live
      // external_s level is never captured into SEIP.
      sflop_vec    = '0;
      sflop_vec[1] = ssip_reg;
      sflop_vec[5] = stip_reg;
      sflop_vec[9] = seip_reg;
   end

   assign deleg_s = mideleg_i & S_MASK;
   assign sip_val = mip & deleg_s;
   assign sie_val = mie_reg & deleg_s;

   always_comb begin
      bus.csr_hit_o   = 1'b0;
      bus.csr_rdata_o = '0;
      case (bus.csr_addr_i)
         CSR_MIP: begin bus.csr_hit_o = 1'b1; bus.csr_rdata_o = mip;     end
         CSR_MIE: begin bus.csr_hit_o = 1'b1; bus.csr_rdata_o = mie_reg; end
         CSR_SIP: begin bus.csr_hit_o = 1'b1; bus.csr_rdata_o = sip_val; end
         CSR_SIE: begin bus.csr_hit_o = 1'b1; bus.csr_rdata_o = sie_val; end
         default: ;
      endcase
   end

   assign wr_en = bus.csr_we_i && bus.csr_hit_o && (bus.csr_op_i != CSR_OP_READ);

   always_comb begin
      mie_next  = mie_reg;
      ssip_next = ssip_reg;
      stip_next = stip_reg;
      seip_next = seip_reg;
      wr_new    = '0;
      if (wr_en) begin
         case (bus.csr_addr_i)
            CSR_MIE: begin
               wr_new   = apply_op(bus.csr_op_i, mie_reg, bus.csr_wdata_i);
               mie_next = wr_new & MIE_MASK;
            end
            CSR_SIE: begin
               wr_new   = apply_op(bus.csr_op_i, sie_val, bus.csr_wdata_i);
               mie_next = (mie_reg & ~deleg_s) | (wr_new & deleg_s);
            end
            CSR_MIP: begin
               wr_new    = apply_op(bus.csr_op_i, sflop_vec, bus.csr_wdata_i);
               ssip_next = wr_new[1];
               stip_next = wr_new[5];
               seip_next = wr_new[9];
            end
            CSR_SIP: begin
               wr_new = apply_op(bus.csr_op_i, sip_val, bus.csr_wdata_i);
               if (mideleg_i[1]) ssip_next = wr_new[1];
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         mie_reg  <= '0;
         ssip_reg <= 1'b0;
         stip_reg <= 1'b0;
         seip_reg <= 1'b0;
      end else begin
         mie_reg  <= mie_next;
         ssip_reg <= ssip_next;
         stip_reg <= stip_next;
         seip_reg <= seip_next;
      end
   end

   assign mip_o = mip;
   assign mie_o = mie_reg;

   // ---------------------------------------------------------------- selection
   logic [11:0] pend;
   logic [11:0] cand_m;
   logic [11:0] cand_s;
   logic [11:0] cand_all;
   logic        m_en;
   logic        s_en;
   logic [4:0]  sel_m;
   logic [4:0]  sel_s;
   logic [4:0]  sel;

   assign pend     = mip[11:0] & mie_reg[11:0];
   assign m_en     = (prv_i != PRV_M) || status_mie_i;
   assign s_en     = (prv_i == PRV_U) || ((prv_i == PRV_S) && status_sie_i);
   assign cand_m   = m_en ? (pend & ~mideleg_i[11:0]) : '0;
   assign cand_s   = s_en ? (pend & mideleg_i[11:0]) : '0;
   assign cand_all = cand_m | cand_s;
   assign sel_m    = pick(cand_m);
   assign sel_s    = pick(cand_s);
   assign sel      = sel_m[4] ? sel_m : sel_s;

   assign wfi_wakeup_o = |pend;

   // ---------------------------------------------------------------- handshake FSM
   state_e     state_reg, state_next;
   logic [4:0] cause_reg, cause_next;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_reg <= IDLE;
         cause_reg <= '0;
      end else begin
         state_reg <= state_next;
         cause_reg <= cause_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      cause_next = cause_reg;
      case (state_reg)
         IDLE: begin
            if (sel[4]) begin
               state_next = PEND;
               cause_next = {1'b1, sel[3:0]};
            end
         end
         PEND: begin
            if (bus.irq_ack_i)                  state_next = HOLDOFF;
            else if (!cand_all[cause_reg[3:0]]) state_next = IDLE;
         end
         HOLDOFF: state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   assign bus.irq_valid_o = (state_reg == PEND);
   assign bus.irq_cause_o = cause_reg;

endmodule

// File: tb/tb_muntjac_irq_ctrl.sv
// Self-checking bench for muntjac_irq_ctrl: directed scenarios plus randomized
// CSR/interrupt mixes checked against a rule-level reference model.
module tb_muntjac_irq_ctrl;

   localparam logic [11:0] A_SIE = 12'h104;
   localparam logic [11:0] A_SIP = 12'h144;
   localparam logic [11:0] A_MIE = 12'h304;
   localparam logic [11:0] A_MIP = 12'h344;
   localparam logic [1:0]  OP_READ  = 2'd0;
   localparam logic [1:0]  OP_WRITE = 2'd1;
   localparam logic [1:0]  OP_SET   = 2'd2;
   localparam logic [1:0]  OP_CLEAR = 2'd3;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        sw, tm, em, es;
   logic [1:0]  prv;
   logic        smie, ssie;
   logic [63:0] mideleg;
   logic [63:0] mip_o, mie_o;
   logic        wfi;

   int errors = 0;
   int checks = 0;

   always #5 clk_i = ~clk_i;

   muntjac_irq_ctrl_if bus();

   muntjac_irq_ctrl #(.SYNC_STAGES(2)) dut (
      .clk_i            (clk_i),
      .rst_ni           (rst_ni),
      .irq_software_m_i (sw),
      .irq_timer_m_i    (tm),
      .irq_external_m_i (em),
      .irq_external_s_i (es),
      .prv_i            (prv),
      .status_mie_i     (smie),
      .status_sie_i     (ssie),
      .mideleg_i        (mideleg),
      .mip_o            (mip_o),
      .mie_o            (mie_o),
      .wfi_wakeup_o     (wfi),
      .bus              (bus)
   );

   function automatic logic [63:0] ref_op(input logic [1:0] op, input logic [63:0] old_val,
                                          input logic [63:0] wd);
      if (op == OP_WRITE) return wd;
      if (op == OP_SET)   return old_val | wd;
      if (op == OP_CLEAR) return old_val & ~wd;
      return old_val;
   endfunction

   // {found, cause}: M-level pending beats S-level; fixed order within each level
   function automatic logic [5:0] ref_cause(input logic [63:0] p_mip, input logic [63:0] p_mie,
                                            input logic [63:0] dl, input logic [1:0] pv,
                                            input logic gm, input logic gs);
      int order [6];
      logic [63:0] p;
      logic m_ok, s_ok;
      order = '{11, 3, 7, 9, 1, 5};
      p    = p_mip & p_mie;
      m_ok = (pv != 2'd3) || gm;
      s_ok = (pv == 2'd0) || ((pv == 2'd1) && gs);
      foreach (order[i]) if (m_ok && p[order[i]] && !dl[order[i]]) return {2'b11, 4'(order[i])};
      foreach (order[i]) if (s_ok && p[order[i]] &&  dl[order[i]]) return {2'b11, 4'(order[i])};
      return 6'd0;
   endfunction

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic csr_op(input logic [1:0] op, input logic [11:0] addr, input logic [63:0] wd);
      bus.csr_we_i    = 1'b1;
      bus.csr_op_i    = op;
      bus.csr_addr_i  = addr;
      bus.csr_wdata_i = wd;
      tick();
      bus.csr_we_i    = 1'b0;
      bus.csr_op_i    = OP_READ;
   endtask

   task automatic csr_rd(input logic [11:0] addr, output logic [63:0] d, output logic h);
      bus.csr_we_i   = 1'b0;
      bus.csr_addr_i = addr;
      #1;
      d = bus.csr_rdata_o;
      h = bus.csr_hit_o;
   endtask

   task automatic wait_level(input logic lvl, input int budget, output logic seen);
      seen = 1'b0;
      for (int i = 0; i <= budget; i++) begin
         if (bus.irq_valid_o === lvl) begin
            seen = 1'b1;
            break;
         end
         if (i < budget) tick();
      end
   endtask

   task automatic test_reset();
      logic [63:0] d;
      logic h;
      rst_ni = 1'b0;
      {sw, tm, em, es} = 4'b0;
      prv = 2'd3; smie = 1'b0; ssie = 1'b0; mideleg = '0;
      bus.csr_we_i = 1'b0; bus.csr_op_i = OP_READ; bus.csr_addr_i = A_MIP;
      bus.csr_wdata_i = '0; bus.irq_ack_i = 1'b0;
      tick(); tick();
      rst_ni = 1'b1;
      checks++; if (bus.irq_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", bus.irq_valid_o); end
      checks++; if (bus.irq_cause_o !== 5'd0) begin errors++; $display("FAIL reset_cause got=%h exp=0", bus.irq_cause_o); end
      checks++; if (mip_o !== 64'd0) begin errors++; $display("FAIL reset_mip got=%h exp=0", mip_o); end
      checks++; if (mie_o !== 64'd0) begin errors++; $display("FAIL reset_mie got=%h exp=0", mie_o); end
      checks++; if (wfi !== 1'b0) begin errors++; $display("FAIL reset_wfi got=%b exp=0", wfi); end
      csr_rd(A_MIP, d, h);
      checks++; if (h !== 1'b1 || d !== 64'd0) begin errors++; $display("FAIL reset_read_mip hit=%b data=%h exp hit=1 data=0", h, d); end
      $display("test_reset done");
   endtask

   task automatic test_ext_m();
      logic seen;
      prv = 2'd3; smie = 1'b1; mideleg = '0;
      csr_op(OP_WRITE, A_MIE, 64'h800);
      em = 1'b1;
      tick();
      checks++; if (bus.irq_valid_o !== 1'b0) begin errors++; $display("FAIL ext_m_lat1 got=%b exp=0", bus.irq_valid_o); end
      tick();
      checks++; if (bus.irq_valid_o !== 1'b0) begin errors++; $display("FAIL ext_m_lat2 got=%b exp=0", bus.irq_valid_o); end
      tick();
      checks++; if (bus.irq_valid_o !== 1'b1 || bus.irq_cause_o !== 5'h1B) begin
         errors++; $display("FAIL ext_m_lat3 valid=%b cause=%h exp valid=1 cause=1b", bus.irq_valid_o, bus.irq_cause_o); end
      bus.irq_ack_i = 1'b1;
      tick();
      bus.irq_ack_i = 1'b0;
      checks++; if (bus.irq_valid_o !== 1'b0) begin errors++; $display("FAIL ext_m_holdoff got=%b exp=0", bus.irq_valid_o); end
      wait_level(1'b1, 3, seen);
      checks++; if (!seen || bus.irq_cause_o !== 5'h1B) begin
         errors++; $display("FAIL ext_m_reassert seen=%b cause=%h exp seen=1 cause=1b", seen, bus.irq_cause_o); end
      em = 1'b0;
      csr_op(OP_WRITE, A_MIE, 64'h0);
      tick(); tick(); tick();
      checks++; if (bus.irq_valid_o !== 1'b0) begin errors++; $display("FAIL ext_m_cleanup got=%b exp=0", bus.irq_valid_o); end
      $display("test_ext_m done");
   endtask

   task automatic test_priority();
      logic seen;
      csr_op(OP_WRITE, A_MIE, 64'h888);
      {sw, tm, em} = 3'b111;
      wait_level(1'b1, 6, seen);
      checks++; if (!seen || bus.irq_cause_o !== 5'h1B) begin
         errors++; $display("FAIL prio_mei seen=%b cause=%h exp seen=1 cause=1b", seen, bus.irq_cause_o); end
      em = 1'b0;
      wait_level(1'b0, 5, seen);
      checks++; if (!seen) begin errors++; $display("FAIL prio_withdraw valid=%b exp=0", bus.irq_valid_o); end
      wait_level(1'b1, 4, seen);
      checks++; if (!seen || bus.irq_cause_o !== 5'h13) begin
         errors++; $display("FAIL prio_msi seen=%b cause=%h exp seen=1 cause=13", seen, bus.irq_cause_o); end
      {sw, tm} = 2'b00;
      csr_op(OP_WRITE, A_MIE, 64'h0);
      tick(); tick(); tick();
      $display("test_priority done");
   endtask

   task automatic test_deleg();
      logic seen;
      int hits;
      mideleg = 64'h20;
      prv = 2'd3; smie = 1'b1; ssie = 1'b0;
      csr_op(OP_WRITE, A_MIE, 64'h20);
      csr_op(OP_SET, A_MIP, 64'h20);
      hits = 0;
      for (int i = 0; i < 4; i++) begin
         if (bus.irq_valid_o !== 1'b0) hits++;
         tick();
      end
      checks++; if (hits != 0) begin errors++; $display("FAIL deleg_m_none valid_cycles=%0d exp=0", hits); end
      checks++; if (wfi !== 1'b1) begin errors++; $display("FAIL deleg_wfi got=%b exp=1", wfi); end
      prv = 2'd1; ssie = 1'b1;
      wait_level(1'b1, 3, seen);
      checks++; if (!seen || bus.irq_cause_o !== 5'h15) begin
         errors++; $display("FAIL deleg_s_sti seen=%b cause=%h exp seen=1 cause=15", seen, bus.irq_cause_o); end
      ssie = 1'b0;
      wait_level(1'b0, 3, seen);
      hits = 0;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (bus.irq_valid_o !== 1'b0) hits++;
      end
      checks++; if (!seen || hits != 0) begin
         errors++; $display("FAIL deleg_s_disabled dropped=%b later_valid_cycles=%0d exp dropped=1 cycles=0", seen, hits); end
      csr_op(OP_CLEAR, A_MIP, 64'h20);
      csr_op(OP_WRITE, A_MIE, 64'h0);
      mideleg = '0; prv = 2'd3; smie = 1'b0;
      tick();
      $display("test_deleg done");
   endtask

   task automatic test_csr_access();
      logic [63:0] d;
      logic h;
      mideleg = '0;
      csr_op(OP_WRITE, A_MIE, 64'h888);
      csr_op(OP_WRITE, A_SIE, 64'h222);
      checks++; if (mie_o !== 64'h888) begin errors++; $display("FAIL sie_undelegated mie=%h exp=888", mie_o); end
      csr_rd(A_SIE, d, h);
      checks++; if (h !== 1'b1 || d !== 64'd0) begin errors++; $display("FAIL sie_read hit=%b data=%h exp hit=1 data=0", h, d); end
      csr_op(OP_SET, A_MIP, 64'h2);
      checks++; if (mip_o !== 64'h2) begin errors++; $display("FAIL mip_set_ssip mip=%h exp=2", mip_o); end
      csr_op(OP_WRITE, A_MIP, 64'hFFFF_FFFF_FFFF_FFFF);
      checks++; if (mip_o !== 64'h222) begin errors++; $display("FAIL mip_write_mask mip=%h exp=222", mip_o); end
      csr_rd(A_SIP, d, h);
      checks++; if (d !== 64'd0) begin errors++; $display("FAIL sip_read_undeleg data=%h exp=0", d); end
      csr_op(OP_CLEAR, A_SIP, 64'h2);
      checks++; if (mip_o !== 64'h222) begin errors++; $display("FAIL sip_clear_undeleg mip=%h exp=222", mip_o); end
      mideleg = 64'h2;
      csr_rd(A_SIP, d, h);
      checks++; if (d !== 64'h2) begin errors++; $display("FAIL sip_read_deleg data=%h exp=2", d); end
      csr_op(OP_CLEAR, A_SIP, 64'h2);
      checks++; if (mip_o !== 64'h220) begin errors++; $display("FAIL sip_clear_deleg mip=%h exp=220", mip_o); end
      csr_rd(12'h300, d, h);
      checks++; if (h !== 1'b0 || d !== 64'd0) begin errors++; $display("FAIL miss_read hit=%b data=%h exp hit=0 data=0", h, d); end
      csr_op(OP_WRITE, 12'h300, 64'hFFFF_FFFF_FFFF_FFFF);
      csr_op(OP_READ, A_MIE, 64'h0);
      checks++; if (mie_o !== 64'h888 || mip_o !== 64'h220) begin
         errors++; $display("FAIL no_write mie=%h mip=%h exp mie=888 mip=220", mie_o, mip_o); end
      csr_op(OP_WRITE, A_MIP, 64'h0);
      csr_op(OP_WRITE, A_MIE, 64'h0);
      mideleg = '0;
      $display("test_csr_access done");
   endtask

   task automatic test_reset_pend();
      logic seen;
      prv = 2'd3; smie = 1'b1; ssie = 1'b0; mideleg = '0;
      csr_op(OP_WRITE, A_MIE, 64'h800);
      em = 1'b1;
      wait_level(1'b1, 5, seen);
      checks++; if (!seen) begin errors++; $display("FAIL rst_pend_setup valid=%b exp=1", bus.irq_valid_o); end
      rst_ni = 1'b0;
      tick();
      checks++; if (bus.irq_valid_o !== 1'b0 || bus.irq_cause_o !== 5'd0 || mie_o !== 64'd0) begin
         errors++; $display("FAIL rst_in_pend valid=%b cause=%h mie=%h exp 0/0/0", bus.irq_valid_o, bus.irq_cause_o, mie_o); end
      em = 1'b0;
      rst_ni = 1'b1;
      tick(); tick(); tick();
      smie = 1'b0;
      csr_op(OP_WRITE, A_MIE, 64'h8);
      sw = 1'b1;
      tick(); tick(); tick();
      checks++; if (wfi !== 1'b1 || bus.irq_valid_o !== 1'b0) begin
         errors++; $display("FAIL wfi_on wfi=%b valid=%b exp wfi=1 valid=0", wfi, bus.irq_valid_o); end
      sw = 1'b0;
      tick(); tick(); tick();
      checks++; if (wfi !== 1'b0) begin errors++; $display("FAIL wfi_off wfi=%b exp=0", wfi); end
      csr_op(OP_WRITE, A_MIE, 64'h0);
      $display("test_reset_pend done");
   endtask

   task automatic test_random();
      logic [63:0] m_mie, m_sfl, m_mip, msk, wd, d;
      logic [1:0]  op;
      logic [5:0]  exp;
      logic        h, seen;
      int          hits;
      m_mie = '0;
      m_sfl = '0;
      for (int it = 0; it < 30; it++) begin
         prv = 2'd3; smie = 1'b0; ssie = 1'b0;
         tick(); tick();
         mideleg = {$urandom, $urandom};
         {sw, tm, em, es} = 4'($urandom);
         op = 2'($urandom_range(1, 3)); wd = {$urandom, $urandom};
         csr_op(op, A_MIE, wd);
         m_mie = ref_op(op, m_mie, wd) & 64'hAAA;
         op = 2'($urandom_range(1, 3)); wd = {$urandom, $urandom};
         csr_op(op, A_MIP, wd);
         m_sfl = ref_op(op, m_sfl, wd) & 64'h222;
         if ($urandom_range(0, 1) == 1) begin
            op = 2'($urandom_range(1, 3)); wd = {$urandom, $urandom};
            csr_op(op, A_SIE, wd);
            msk = mideleg & 64'h222;
            m_mie = (m_mie & ~msk) | (ref_op(op, m_mie & msk, wd) & msk);
         end
         tick(); tick(); tick();
         m_mip = m_sfl | (64'(sw) << 3) | (64'(tm) << 7) | (64'(em) << 11) | (64'(es) << 9);
         checks++; if (mip_o !== m_mip || mie_o !== m_mie) begin
            errors++; $display("FAIL rnd%0d_regs mip=%h mie=%h exp mip=%h mie=%h", it, mip_o, mie_o, m_mip, m_mie); end
         csr_rd(A_SIP, d, h);
         checks++; if (h !== 1'b1 || d !== (m_mip & mideleg & 64'h222)) begin
            errors++; $display("FAIL rnd%0d_sip data=%h exp=%h", it, d, m_mip & mideleg & 64'h222); end
         csr_rd(A_SIE, d, h);
         checks++; if (h !== 1'b1 || d !== (m_mie & mideleg & 64'h222)) begin
            errors++; $display("FAIL rnd%0d_sie data=%h exp=%h", it, d, m_mie & mideleg & 64'h222); end
         checks++; if (wfi !== (|(m_mip & m_mie))) begin
            errors++; $display("FAIL rnd%0d_wfi got=%b exp=%b", it, wfi, |(m_mip & m_mie)); end
         case ($urandom_range(0, 2))
            0:       prv = 2'd0;
            1:       prv = 2'd1;
            default: prv = 2'd3;
         endcase
         smie = 1'($urandom); ssie = 1'($urandom);
         exp = ref_cause(m_mip, m_mie, mideleg, prv, smie, ssie);
         if (exp[5]) begin
            wait_level(1'b1, 3, seen);
            checks++; if (!seen || bus.irq_cause_o !== exp[4:0]) begin
               errors++; $display("FAIL rnd%0d_cause seen=%b cause=%h exp=%h", it, seen, bus.irq_cause_o, exp[4:0]); end
            bus.irq_ack_i = 1'b1;
            tick();
            bus.irq_ack_i = 1'b0;
            checks++; if (bus.irq_valid_o !== 1'b0) begin
               errors++; $display("FAIL rnd%0d_ack valid=%b exp=0", it, bus.irq_valid_o); end
         end else begin
            hits = 0;
            for (int i = 0; i < 4; i++) begin
               tick();
               if (bus.irq_valid_o !== 1'b0) hits++;
            end
            checks++; if (hits != 0) begin
               errors++; $display("FAIL rnd%0d_none valid_cycles=%0d exp=0", it, hits); end
         end
         $display("rnd%0d prv=%0d mie=%b sie=%b mip=%h mie_reg=%h exp=%h", it, prv, smie, ssie, m_mip, m_mie, exp);
      end
      {sw, tm, em, es} = 4'b0;
      prv = 2'd3; smie = 1'b0; ssie = 1'b0;
   endtask

   initial begin
      test_reset();
      test_ext_m();
      test_priority();
      test_deleg();
      test_csr_access();
      test_reset_pend();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/muntjac_irq_ctrl.md
MUNTJAC_IRQ_CTRL -- requirements
Module: muntjac_irq_ctrl

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, giving the number of synchronizer flops per external interrupt input (legal range 1..4).
REQ-002 SHALL have port clk_i, input, 1, the single clock.
REQ-003 SHALL have port rst_ni, input, 1, reset: synchronous, active-low.
REQ-004 SHALL have ports irq_software_m_i, irq_timer_m_i, irq_external_m_i and irq_external_s_i, input, 1 each, asynchronous level interrupt requests.
REQ-005 SHALL have port prv_i, input, 2, current privilege (priv_lvl_e).
REQ-006 SHALL have ports status_mie_i and status_sie_i, input, 1 each, the mstatus global enables.
REQ-007 SHALL have port mideleg_i, input, 64, the interrupt delegation mask.
REQ-008 SHALL have ports csr_we_i (input, 1), csr_op_i (input, 2, csr_op_e), csr_addr_i (input, 12) and csr_wdata_i (input, 64), the CSR access port.
REQ-009 SHALL have ports csr_rdata_o (output, 64) and csr_hit_o (output, 1), the read data and address-match flag.
REQ-010 SHALL have ports mip_o and mie_o, output, 64 each, the live register values.
REQ-011 SHALL have ports irq_valid_o (output, 1), irq_cause_o (output, 5, exc_cause_e) and irq_ack_i (input, 1), the trap request handshake.
REQ-012 SHALL have port wfi_wakeup_o, output, 1, the WFI wake indication.

Function
REQ-013 Each irq input SHALL pass through SYNC_STAGES flops before use; the flops reset to 0.
REQ-014 mip bits 3, 7 and 11 SHALL equal the synchronized software_m, timer_m and external_m inputs, and CSR writes SHALL NOT change them.
REQ-015 mip bit 9 (SEIP) SHALL read as the software SEIP flop OR the synchronized external_s input; a CSR write SHALL update only the flop.
REQ-016 mip bits 1 and 5 SHALL be software flops; all other mip and mie bits SHALL read 0.
REQ-017 csr_hit_o SHALL be 1 only for CSR_MIP, CSR_MIE, CSR_SIP and CSR_SIE.
REQ-018 csr_rdata_o SHALL be combinational: mip for CSR_MIP, mie for CSR_MIE, mip & mideleg_i & 0x222 for CSR_SIP, mie & mideleg_i & 0x222 for CSR_SIE, and 0 otherwise.
REQ-019 A write SHALL occur at the clock edge when csr_we_i=1, csr_hit_o=1 and csr_op_i is not CSR_OP_READ.
REQ-020 The new value SHALL be wdata for WRITE, old|wdata for SET, and old&~wdata for CLEAR.
REQ-021 An MIE write SHALL update mie bits 1, 3, 5, 7, 9 and 11; an MIP write SHALL update the SEIP, STIP and SSIP flops.
REQ-022 A SIE write SHALL update only mie bits among {1, 5, 9} whose mideleg_i bit is 1; a SIP write SHALL update only SSIP, and only if mideleg_i[1]=1.
REQ-023 pend SHALL be mip & mie; pend_m = pend & ~mideleg_i, and pend_s = pend & mideleg_i.
REQ-024 The M-level candidate set SHALL be pend_m when prv_i is not M, or when prv_i=M and status_mie_i=1; otherwise it SHALL be empty.
REQ-025 The S-level candidate set SHALL be pend_s when prv_i=U, or when prv_i=S and status_sie_i=1; otherwise it SHALL be empty.
REQ-026 Selection SHALL take the M-level set over the S-level set; within a set, priority SHALL be MEI > MSI > MTI > SEI > SSI > STI.
REQ-027 The FSM SHALL have states IDLE, PEND and HOLDOFF.
REQ-028 IDLE SHALL move to PEND on the next edge when a candidate exists, and SHALL register irq_cause_o to that selection.
REQ-029 PEND SHALL drive irq_valid_o=1 and hold irq_cause_o stable.
REQ-030 PEND with irq_ack_i=1 SHALL move to HOLDOFF; PEND with the latched cause no longer a candidate and no ack SHALL move to IDLE (withdraw).
REQ-031 HOLDOFF SHALL drive irq_valid_o=0 for exactly one cycle, then move to IDLE.
REQ-032 irq_ack_i SHALL be ignored outside PEND.
REQ-033 Latency from input assertion to irq_valid_o SHALL be SYNC_STAGES+1 cycles when enabled; a CSR write SHALL affect irq_valid_o one cycle after the write edge.
REQ-034 A simultaneous ack and CSR write SHALL both take effect in the same cycle.
REQ-035 wfi_wakeup_o SHALL be combinational |pend, independent of status enables and prv_i.

Reset
REQ-036 On an edge with rst_ni=0: sync flops, mie, SEIP/STIP/SSIP flops and irq_cause_o SHALL clear to 0; state SHALL be IDLE and irq_valid_o SHALL be 0.
REQ-037 Reset asserted in PEND or HOLDOFF SHALL return the block to IDLE at that edge with no ack required.

Verification
REQ-038 prv=M, mstatus.mie=1, MIE=0x800; raise irq_external_m_i -> irq_valid_o=1 after 3 cycles with cause {1,11}; ack -> valid low for 1 cycle, then high again while input held.
REQ-039 MIE=0x888, all three M inputs high -> cause {1,11}; drop external -> after withdraw and re-selection, cause {1,3}.
REQ-040 mideleg=0x20, MIE=0x20, prv=M, MIP SET 0x20 -> no valid; prv=S, sie=1 -> cause {1,5}; prv=S, sie=0 -> none.
REQ-041 mideleg=0; SIE write 0x222 -> mie unchanged, SIE reads 0; SIP CLEAR with mideleg[1]=1 clears SSIP.
REQ-042 Drive rst_ni low during PEND -> next edge valid=0, cause=0, mie=0; wfi_wakeup_o tracks pend with status enables off.
